// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
//  Shared types and constants for the 3-stage pipeline hazard controller.
//  - type_hz_state_e : controller FSM states
//  - FOR_*           : execute-stage operand forwarding selects
//  - WB_*            : MW-stage writeback source codes
// -----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      TRAP     = 2'd2
   } type_hz_state_e;

   // Forward selects driving the execute operand MUXes
   localparam logic [1:0] FOR_REG = 2'd0;  // register file read data
   localparam logic [1:0] FOR_ALU = 2'd1;  // MW alu_out
   localparam logic [1:0] FOR_WB  = 2'd2;  // MW final writeback data

   // MW writeback source codes
   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;
   localparam logic [1:0] WB_CSR = 2'd3;

   localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//  Bundle of pipeline status and hazard-control signals.
//  master : pipeline datapath side (drives stage status, receives control)
//  slave  : hazard controller (consumes status, drives stall/flush/forward)
//  Inputs to controller : e_valid, e_rs1, e_rs2, e_use_rs1, e_use_rs2, br_taken,
//                         mw_valid, mw_rd, mw_reg_wr, mw_wb_sel, mw_mem_req,
//                         mem_ack, trap_req
//  Outputs of controller: for_a, for_b, stall_f, stall_e, flush_e, trap_take,
//                         bus_err, stall_cnt[CNT_W]
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic             e_valid;
   logic [4:0]       e_rs1;
   logic [4:0]       e_rs2;
   logic             e_use_rs1;
   logic             e_use_rs2;
   logic             br_taken;
   logic             mw_valid;
   logic [4:0]       mw_rd;
   logic             mw_reg_wr;
   logic [1:0]       mw_wb_sel;
   logic             mw_mem_req;
   logic             mem_ack;
   logic             trap_req;

   logic [1:0]       for_a;
   logic [1:0]       for_b;
   logic             stall_f;
   logic             stall_e;
   logic             flush_e;
   logic             trap_take;
   logic             bus_err;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output e_valid, e_rs1, e_rs2, e_use_rs1, e_use_rs2, br_taken,
             mw_valid, mw_rd, mw_reg_wr, mw_wb_sel, mw_mem_req, mem_ack, trap_req,
      input  for_a, for_b, stall_f, stall_e, flush_e, trap_take, bus_err, stall_cnt
   );

   modport slave (
      input  e_valid, e_rs1, e_rs2, e_use_rs1, e_use_rs2, br_taken,
             mw_valid, mw_rd, mw_reg_wr, mw_wb_sel, mw_mem_req, mem_ack, trap_req,
      output for_a, for_b, stall_f, stall_e, flush_e, trap_take, bus_err, stall_cnt
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
//  Combinational forward-select for one execute-stage source operand.
//  mw_valid_i, mw_reg_wr_i, mw_rd_i, mw_wb_sel_i : MW-stage producer info
//  e_rs_i, e_use_rs_i                            : DE-stage consumer info
//  for_sel_o                                     : FOR_REG / FOR_ALU / FOR_WB
// -----------------------------------------------------------------------------
module hazard_fwd_unit
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic       mw_valid_i,
   input  logic       mw_reg_wr_i,
   input  logic [4:0] mw_rd_i,
   input  logic [1:0] mw_wb_sel_i,
   input  logic [4:0] e_rs_i,
   input  logic       e_use_rs_i,
   output logic [1:0] for_sel_o
);

   always_comb begin
      for_sel_o = FOR_REG;
      // x0 is hard-wired zero, so a write to it is never a real producer
      if (mw_valid_i && mw_reg_wr_i && e_use_rs_i &&
          (mw_rd_i != REG_X0) && (mw_rd_i == e_rs_i)) begin
         // Only ALU results are ready early; every other source needs the muxed wbdata
         for_sel_o = (mw_wb_sel_i == WB_ALU) ? FOR_ALU : FOR_WB;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//  Hazard/sequencing controller for the F | DE | MW pipeline: forwarding
//  selects, memory-access stalls with timeout, branch flush, trap entry.
//  clk  : clock, rising edge
//  rst  : asynchronous reset, active-high
//  hz   : pipeline_hazard_ctrl_if.slave (status in, stall/flush/forward out)
//  MEM_TIMEOUT : max cycles of an unacknowledged access before abort (>=2)
//  CNT_W       : width of the saturating stall counter
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   pipeline_hazard_ctrl_if.slave  hz
);

   localparam int unsigned TW = $clog2(MEM_TIMEOUT);
   localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

   type_hz_state_e   state_q, state_d;
   logic [TW-1:0]    wcnt_q, wcnt_d;
   logic [CNT_W-1:0] scnt_q, scnt_d;

   logic [1:0] fwd_a, fwd_b;
   logic       mem_pend;
   logic       stall_w, flush_w, trap_w, berr_w;

   hazard_fwd_unit u_fwd_a (
      .mw_valid_i  (hz.mw_valid),
      .mw_reg_wr_i (hz.mw_reg_wr),
      .mw_rd_i     (hz.mw_rd),
      .mw_wb_sel_i (hz.mw_wb_sel),
      .e_rs_i      (hz.e_rs1),
      .e_use_rs_i  (hz.e_use_rs1),
      .for_sel_o   (fwd_a)
   );

   hazard_fwd_unit u_fwd_b (
      .mw_valid_i  (hz.mw_valid),
      .mw_reg_wr_i (hz.mw_reg_wr),
      .mw_rd_i     (hz.mw_rd),
      .mw_wb_sel_i (hz.mw_wb_sel),
      .e_rs_i      (hz.e_rs2),
      .e_use_rs_i  (hz.e_use_rs2),
      .for_sel_o   (fwd_b)
   );

   // Request acknowledged in the same cycle needs no stall at all
   assign mem_pend = hz.mw_valid & hz.mw_mem_req & ~hz.mem_ack;

   // State and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         wcnt_q  <= '0;
         scnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         scnt_q  <= scnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      unique case (state_q)
         RUN: begin
            if (mem_pend) begin
               state_d = MEM_WAIT;
               wcnt_d  = TW'(1);
            end else if (hz.trap_req && hz.e_valid) begin
               state_d = TRAP;
            end
         end
         MEM_WAIT: begin
            if (hz.mem_ack || (wcnt_q == WAIT_LAST)) begin
               state_d = RUN;
               wcnt_d  = '0;
            end else begin
               wcnt_d  = wcnt_q + 1'b1;
            end
         end
         TRAP: begin
            state_d = RUN;
         end
         default: begin
            state_d = RUN;
            wcnt_d  = '0;
         end
      endcase
   end

   // Output logic
   always_comb begin
      stall_w = 1'b0;
      flush_w = 1'b0;
      trap_w  = 1'b0;
      berr_w  = 1'b0;
      unique case (state_q)
         RUN: begin
            if (mem_pend) begin
               stall_w = 1'b1;
            end else if (hz.trap_req && hz.e_valid) begin
               // Trap beats a same-cycle branch; the branch re-executes after mret
               flush_w = 1'b1;
               trap_w  = 1'b1;
            end else if (hz.br_taken && hz.e_valid) begin
               flush_w = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (hz.mem_ack) begin
               stall_w = 1'b0;
            end else if (wcnt_q == WAIT_LAST) begin
               berr_w  = 1'b1;
            end else begin
               stall_w = 1'b1;
            end
         end
         TRAP: begin
            // Kill the instruction fetched down the pre-trap path
            flush_w = 1'b1;
         end
         default: ;
      endcase

      scnt_d = (stall_w && (scnt_q != '1)) ? scnt_q + 1'b1 : scnt_q;

      // Outputs are forced to their reset values while rst is held, even if
      // the pipeline status inputs would otherwise request control actions.
      hz.stall_f   = stall_w & ~rst;
      hz.stall_e   = stall_w & ~rst;
      hz.flush_e   = flush_w & ~rst;
      hz.trap_take = trap_w  & ~rst;
      hz.bus_err   = berr_w  & ~rst;
      hz.for_a     = rst ? FOR_REG : fwd_a;
      hz.for_b     = rst ? FOR_REG : fwd_b;
      hz.stall_cnt = scnt_q;
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

   localparam int MT = 4;
   localparam int CW = 4;
   localparam int SAT = (1 << CW) - 1;

   typedef struct {
      logic       ev;
      logic [4:0] rs1, rs2;
      logic       u1, u2, br, mv;
      logic [4:0] rd;
      logic       wr;
      logic [1:0] wb;
      logic       mreq, ack, trap;
   } stim_t;

   typedef struct {
      int fa, fb, sf, se, fl, tt, be, sc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz ();

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // reference model state: 0 run, 1 waiting on memory, 2 trap cycle
   int m_st = 0, m_cnt = 0, m_sc = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int fwd_exp(input stim_t s, input logic [4:0] rs, input logic use_rs);
      if (s.mv && s.wr && use_rs && s.rd != 5'd0 && s.rd == rs)
         return (s.wb == 2'd0) ? 1 : 2;
      return 0;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '{ev:1'b0, rs1:5'd0, rs2:5'd0, u1:1'b0, u2:1'b0, br:1'b0, mv:1'b0,
            rd:5'd0, wr:1'b0, wb:2'd0, mreq:1'b0, ack:1'b0, trap:1'b0};
      return s;
   endfunction

   task automatic drive(input stim_t s);
      hz.e_valid    = s.ev;
      hz.e_rs1      = s.rs1;
      hz.e_rs2      = s.rs2;
      hz.e_use_rs1  = s.u1;
      hz.e_use_rs2  = s.u2;
      hz.br_taken   = s.br;
      hz.mw_valid   = s.mv;
      hz.mw_rd      = s.rd;
      hz.mw_reg_wr  = s.wr;
      hz.mw_wb_sel  = s.wb;
      hz.mw_mem_req = s.mreq;
      hz.mem_ack    = s.ack;
      hz.trap_req   = s.trap;
   endtask

   // Drive one cycle of stimulus, push the expected outputs, advance the model.
   task automatic step(input stim_t s);
      exp_t e;
      int   nst, ncnt;
      @(negedge clk);
      drive(s);
      e = '{fa:fwd_exp(s, s.rs1, s.u1), fb:fwd_exp(s, s.rs2, s.u2),
            sf:0, se:0, fl:0, tt:0, be:0, sc:m_sc};
      nst  = m_st;
      ncnt = m_cnt;
      if (m_st == 0) begin
         if (s.mv && s.mreq && !s.ack) begin
            e.sf = 1; e.se = 1; nst = 1; ncnt = 1;
         end else if (s.trap && s.ev) begin
            e.fl = 1; e.tt = 1; nst = 2;
         end else if (s.br && s.ev) begin
            e.fl = 1;
         end
      end else if (m_st == 1) begin
         if (s.ack) begin
            nst = 0; ncnt = 0;
         end else if (m_cnt == MT - 1) begin
            e.be = 1; nst = 0; ncnt = 0;
         end else begin
            e.sf = 1; e.se = 1; ncnt = m_cnt + 1;
         end
      end else begin
         e.fl = 1; nst = 0;
      end
      exp_q.push_back(e);
      if (e.sf == 1 && m_sc < SAT) m_sc++;
      m_st  = nst;
      m_cnt = ncnt;
   endtask

   // Scoreboard: compare every pushed expectation mid-cycle, away from posedge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("for_a",     32'(hz.for_a),     32'(e.fa));
            check_eq("for_b",     32'(hz.for_b),     32'(e.fb));
            check_eq("stall_f",   32'(hz.stall_f),   32'(e.sf));
            check_eq("stall_e",   32'(hz.stall_e),   32'(e.se));
            check_eq("flush_e",   32'(hz.flush_e),   32'(e.fl));
            check_eq("trap_take", 32'(hz.trap_take), 32'(e.tt));
            check_eq("bus_err",   32'(hz.bus_err),   32'(e.be));
            check_eq("stall_cnt", 32'(hz.stall_cnt), 32'(e.sc));
         end
      end
   end

   initial begin
      stim_t s;

      // Reset with a forwarding match and pending request present: outputs must stay 0
      rst = 1'b1;
      s = idle();
      s.mv = 1; s.wr = 1; s.rd = 5'd5; s.ev = 1; s.rs1 = 5'd5; s.u1 = 1;
      s.mreq = 1; s.trap = 1; s.br = 1;
      drive(s);
      #3;
      check_eq("rst_for_a",     32'(hz.for_a),     32'd0);
      check_eq("rst_stall_f",   32'(hz.stall_f),   32'd0);
      check_eq("rst_flush_e",   32'(hz.flush_e),   32'd0);
      check_eq("rst_trap_take", 32'(hz.trap_take), 32'd0);
      check_eq("rst_stall_cnt", 32'(hz.stall_cnt), 32'd0);
      drive(idle());
      @(negedge clk);
      rst = 1'b0;

      // 1: ALU result forwarded to rs1; x0 never forwarded
      s = idle();
      s.mv = 1; s.wr = 1; s.rd = 5'd5; s.wb = 2'd0; s.ev = 1; s.rs1 = 5'd5; s.u1 = 1;
      step(s); #3;
      check_eq("t1_for_a_alu", 32'(hz.for_a), 32'd1);
      s.rd = 5'd0; s.rs1 = 5'd0;
      step(s); #3;
      check_eq("t1_for_a_x0", 32'(hz.for_a), 32'd0);

      // 2: memory result needs wbdata; both operands; unused operand not forwarded
      s = idle();
      s.mv = 1; s.wr = 1; s.rd = 5'd7; s.wb = 2'd1; s.ev = 1;
      s.rs1 = 5'd3; s.u1 = 1; s.rs2 = 5'd7; s.u2 = 1;
      step(s); #3;
      check_eq("t2_for_b_wb", 32'(hz.for_b), 32'd2);
      s.rs1 = 5'd7;
      step(s); #3;
      check_eq("t2_for_a_both", 32'(hz.for_a), 32'd2);
      check_eq("t2_for_b_both", 32'(hz.for_b), 32'd2);
      s.u1 = 0;
      step(s);
      s.wr = 0;
      step(s);

      // 3: ack after 3 stall cycles
      s = idle();
      s.mv = 1; s.mreq = 1;
      step(s); step(s); step(s);
      s.ack = 1;
      step(s); #3;
      check_eq("t3_ack_no_stall", 32'(hz.stall_f), 32'd0);
      step(idle()); #3;
      check_eq("t3_stall_cnt", 32'(hz.stall_cnt), 32'd3);

      // same-cycle ack: no stall at all
      s = idle();
      s.mv = 1; s.mreq = 1; s.ack = 1;
      step(s); #3;
      check_eq("t3_same_cycle_ack", 32'(hz.stall_f), 32'd0);

      // 4: timeout with MEM_TIMEOUT=4
      s = idle();
      s.mv = 1; s.mreq = 1;
      step(s); step(s); step(s); step(s); #3;
      check_eq("t4_bus_err", 32'(hz.bus_err), 32'd1);
      check_eq("t4_stall_drop", 32'(hz.stall_f), 32'd0);
      step(idle()); #3;
      check_eq("t4_bus_err_pulse", 32'(hz.bus_err), 32'd0);

      // 5: trap and branch together: trap wins, flush over two cycles
      s = idle();
      s.ev = 1; s.br = 1; s.trap = 1;
      step(s); #3;
      check_eq("t5_trap_take", 32'(hz.trap_take), 32'd1);
      check_eq("t5_flush_take", 32'(hz.flush_e), 32'd1);
      step(s); #3;
      check_eq("t5_flush_trap", 32'(hz.flush_e), 32'd1);
      check_eq("t5_no_retake", 32'(hz.trap_take), 32'd0);
      step(idle());

      // Branch alone, and requests ignored while waiting on memory
      s = idle(); s.ev = 1; s.br = 1;
      step(s);
      s = idle(); s.mv = 1; s.mreq = 1;
      step(s);
      s.ev = 1; s.trap = 1; s.br = 1;
      step(s);
      s.ack = 1;
      step(s);
      step(idle());

      // Randomised traffic
      for (int i = 0; i < 300; i++) begin
         s.ev   = 1'($urandom_range(0, 3) != 0);
         s.rs1  = 5'($urandom_range(0, 3));
         s.rs2  = 5'($urandom_range(0, 3));
         s.u1   = 1'($urandom);
         s.u2   = 1'($urandom);
         s.br   = 1'($urandom_range(0, 4) == 0);
         s.mv   = 1'($urandom_range(0, 3) != 0);
         s.rd   = 5'($urandom_range(0, 3));
         s.wr   = 1'($urandom);
         s.wb   = 2'($urandom);
         s.mreq = 1'($urandom_range(0, 3) == 0);
         s.ack  = 1'($urandom_range(0, 4) == 0);
         s.trap = 1'($urandom_range(0, 6) == 0);
         step(s);
      end
      step(idle());

      // Saturation of the stall counter via repeated timeouts
      s = idle(); s.mv = 1; s.mreq = 1;
      for (int i = 0; i < 6 * MT; i++) step(s);
      step(idle()); #3;
      check_eq("sat_stall_cnt", 32'(hz.stall_cnt), 32'(SAT));

      // 6: asynchronous reset while in MEM_WAIT
      s = idle(); s.mv = 1; s.mreq = 1;
      step(s); step(s); #3;
      check_eq("t6_pre_stall", 32'(hz.stall_f), 32'd1);
      rst = 1'b1;
      #1;
      check_eq("t6_stall_f_drop", 32'(hz.stall_f), 32'd0);
      check_eq("t6_stall_e_drop", 32'(hz.stall_e), 32'd0);
      check_eq("t6_stall_cnt_clr", 32'(hz.stall_cnt), 32'd0);
      m_st = 0; m_cnt = 0; m_sc = 0;
      drive(idle());
      @(negedge clk);
      rst = 1'b0;
      // Back in RUN: a fresh ack in the first cycle must not stall
      s = idle(); s.mv = 1; s.mreq = 1; s.ack = 1;
      step(s);
      step(idle());
      step(idle());
      @(negedge clk);
      #4;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
